magma_core: RTL
===============

Name: magma_core

Overview:
- Iterative GOST R 34.12-2015 Magma (64-bit block, 256-bit key) encrypt/decrypt engine.
- Runs all 32 Feistel rounds internally, with RPC rounds unrolled per clock, and generates its own round keys.
- Successor to the single-round datapath. Adds a parametrised unroll factor, a mode select, an internal key schedule, the final no-swap round, and a busy/done handshake.
- Sits between the SD data path and the key store. It is reused by the MAC and CTR wrappers.

Parameters:
- RPC, 1, rounds computed per clock cycle. Legal values are 1, 2, 4 and 8; any other value triggers a simulation $error at elaboration.

Ports:
- iclk  input  1  clock
- irst  input  1  reset, synchronous, active-high; clock iclk
- istart  input  1  start request, sampled on the rising edge of iclk
- idecrypt  input  1  0 = encrypt, 1 = decrypt; latched with istart
- iblock  input  64  input block; bits [63:32] = a1 (left), bits [31:0] = a0 (right); latched with istart
- ikey  input  256  key; k0 = ikey[255:224] … k7 = ikey[31:0]; latched with istart
- oblock  output  64  result block; valid when odone = 1 and held until the next accepted start
- odone  output  1  one-cycle pulse, result valid
- obusy  output  1  high while rounds are being computed

Behaviour:
- Reset values (also apply when irst is asserted mid-operation):
  - state = IDLE, round counter = 0
  - odone = 0, obusy = 0, oblock = 0
  - latched block, key and mode cleared
  - any in-flight operation is dropped with no odone pulse
- States: IDLE, RUN, DONE.
- IDLE:
  - istart = 1: latch iblock, ikey and idecrypt; set counter r = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle applies RPC consecutive rounds r … r+RPC-1 combinationally, then r += RPC.
  - When the batch containing round 31 completes, go to DONE.
  - istart is ignored while in RUN.
- DONE:
  - odone = 1 for exactly one cycle; oblock holds the result.
  - istart = 1 in DONE is accepted, identical to IDLE acceptance, and goes straight to RUN. This gives back-to-back operation.
  - Otherwise go to IDLE.
- Outputs by state:
  - obusy = 1 exactly in RUN.
  - odone = 1 exactly in DONE.
  - oblock is registered and updates only on entry to DONE (and on reset).
- Latency: odone is high in the cycle that follows 32/RPC + 1 rising edges after the edge that accepts istart.
  - RPC=1: 33 cycles
  - RPC=2: 17 cycles
  - RPC=4: 9 cycles
  - RPC=8: 5 cycles
- Throughput, back-to-back: one block every 32/RPC + 1 cycles.
- Round function g_k(a):
  - t = (a + k) mod 2^32
  - apply the existing s_box module to t (eight 4-bit pi substitutions)
  - rotate left by 11
- Rounds 0..30: (a1, a0) ← (a0, g_k(a0) XOR a1).
- Round 31, final: (a1, a0) ← (g_k(a0) XOR a1, a0), i.e. no swap.
- Key index for round r:
  - encrypt: r < 24 ? r mod 8 : 7 − (r mod 8)
  - decrypt: r < 8 ? r mod 8 : 7 − (r mod 8)
- The key schedule uses only the latched key. Changing ikey or idecrypt during RUN has no effect.
- Counter width is 5 bits; it never wraps during an operation.
- One s_box instance per unrolled round (RPC instances total).

Test Plan:
- Encrypt (RPC=1): ikey = ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, iblock = fedcba9876543210 → odone at cycle 33, oblock = 4ee901e5c2d8ca3d, obusy high for 32 cycles.
- Decrypt (RPC=1): same key, idecrypt = 1, iblock = 4ee901e5c2d8ca3d → oblock = fedcba9876543210.
- Unrolled: repeat both vectors with RPC=2, 4 and 8 → identical results, with odone at cycles 17, 9 and 5 respectively.
- Busy and back-to-back:
  - pulse istart with different data mid-RUN → ignored, original result returned;
  - assert istart during the DONE cycle with a new block → accepted, second odone exactly 32/RPC + 1 cycles later.
- Reset mid-op: assert irst at cycle 10 of an encrypt → next cycle odone = 0, obusy = 0, oblock = 0; no odone follows; a fresh encrypt then yields 4ee901e5c2d8ca3d.
- Input stability: change ikey, idecrypt and iblock every cycle during RUN → result unaffected.

Source files
------------

// File: rtl/magma_core.sv
// Iterative GOST R 34.12-2015 Magma block cipher core (64-bit block, 256-bit key).
// RPC Feistel rounds are evaluated per clock; the round keys come from the latched key.

module s_box (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    // Entry n of each pi table lives at bits [4n+3:4n]; pi0 substitutes the lowest nibble.
    localparam logic [63:0] PI [8] = '{
        64'h1F307D8E9B5A264C,
        64'hF0DB74E1C5A93286,
        64'h069C471EDAF2853B,
        64'hB9E35A076F4D128C,
        64'hC24BE390D618A5F7,
        64'h0E34187BAC296FD5,
        64'h73AD0B4FC19652E8,
        64'h2BC96AF43850DE71
    };

    for (genvar i = 0; i < 8; i++) begin : g_pi
        assign dout[4*i +: 4] = PI[i][{din[4*i +: 4], 2'b00} +: 4];
    end
endmodule

module magma_core #(
    parameter int RPC = 1
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic         idecrypt,
    input  logic [63:0]  iblock,
    input  logic [255:0] ikey,
    output logic [63:0]  oblock,
    output logic         odone,
    output logic         obusy
);
    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
        $error("magma_core: RPC must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [4:0]    rnd;
    logic [63:0]   blk;
    logic [255:0]  key;
    logic          dec;

    logic [31:0]   a1 [RPC+1];
    logic [31:0]   a0 [RPC+1];

    // Encryption walks k0..k7 three times then backwards; decryption walks forwards once then backwards.
    function automatic logic [2:0] key_idx(input logic [4:0] r, input logic d);
        logic fwd;
        fwd = d ? (r < 5'd8) : (r < 5'd24);
        return fwd ? r[2:0] : ~r[2:0];
    endfunction

    assign a1[0] = blk[63:32];
    assign a0[0] = blk[31:0];

    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [4:0]  r_j;
        logic [2:0]  kidx;
        logic [31:0] rk;
        logic [31:0] sum;
        logic [31:0] sub;
        logic [31:0] f;

        assign r_j  = rnd + 5'(j);
        assign kidx = key_idx(r_j, dec);
        // k_i sits at ikey[255-32i -: 32]; ~kidx is 7-i, the 32-bit word index from the bottom.
        assign rk   = key[{~kidx, 5'b00000} +: 32];
        assign sum  = a0[j] + rk;

        s_box u_s_box (
            .din  (sum),
            .dout (sub)
        );

        assign f = {sub[20:0], sub[31:21]} ^ a1[j];

        // Round 31 is the final one and leaves the halves unswapped.
        assign a1[j+1] = (r_j == 5'd31) ? f     : a0[j];
        assign a0[j+1] = (r_j == 5'd31) ? a0[j] : f;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state  <= IDLE;
            rnd    <= 5'd0;
            blk    <= 64'd0;
            key    <= 256'd0;
            dec    <= 1'b0;
            oblock <= 64'd0;
            odone  <= 1'b0;
            obusy  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    odone <= 1'b0;
                    if (istart) begin
                        blk   <= iblock;
                        key   <= ikey;
                        dec   <= idecrypt;
                        rnd   <= 5'd0;
                        state <= RUN;
                        obusy <= 1'b1;
                    end else begin
                        state <= IDLE;
                        obusy <= 1'b0;
                    end
                end
                RUN: begin
                    blk <= {a1[RPC], a0[RPC]};
                    if (rnd == 5'(32 - RPC)) begin
                        rnd    <= 5'd0;
                        state  <= DONE;
                        obusy  <= 1'b0;
                        odone  <= 1'b1;
                        oblock <= {a1[RPC], a0[RPC]};
                    end else begin
                        rnd <= rnd + 5'(RPC);
                    end
                end
                default: begin
                    state <= IDLE;
                    odone <= 1'b0;
                    obusy <= 1'b0;
                end
            endcase
        end
    end
endmodule
